// File: rtl/auto_load_seq.sv
// auto_load_seq: responder side of the POR auto-load handshake.
// On AL_START it fetches NWORDS words from the PROM readback buffer and writes
// each one into the config register file. When the load completes, or when a
// word times out, it raises AL_DONE. All outputs come straight from flops.
module auto_load_seq #(
  parameter int NWORDS = 16,
  parameter int AW     = 4,
  parameter int DW     = 16,
  parameter int TMO    = 1023
) (
  input  logic          CLK,
  input  logic          EOS,
  input  logic          AL_START,
  output logic          AL_DONE,
  output logic          AL_ERR,
  output logic [2:0]    AL_STATE,
  output logic          RD_REQ,
  output logic [AW-1:0] RD_ADDR,
  input  logic [DW-1:0] RD_DATA,
  input  logic          RD_VLD,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output logic [DW-1:0] WR_DATA
);

  localparam int TW = 10;
  // Leave Wait_Data once TMO cycles have passed without RD_VLD.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(NWORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t          state_reg,   state_next;
  logic [AW-1:0]   cnt_reg,     cnt_next;
  logic [TW-1:0]   tmo_reg,     tmo_next;
  logic            done_reg,    done_next;
  logic            err_reg,     err_next;
  logic            rd_req_reg,  rd_req_next;
  logic [AW-1:0]   rd_addr_reg, rd_addr_next;
  logic            wr_en_reg,   wr_en_next;
  logic [AW-1:0]   wr_addr_reg, wr_addr_next;
  logic [DW-1:0]   wr_data_reg, wr_data_next;

  // State and output registers. EOS low aborts a load immediately; any
  // config writes that were already issued stay in the register file.
  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      tmo_reg     <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rd_req_reg  <= 1'b0;
      rd_addr_reg <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      tmo_reg     <= tmo_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      rd_req_reg  <= rd_req_next;
      rd_addr_reg <= rd_addr_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Next-state logic. Each one-cycle strobe (RD_REQ, WR_EN) is set on the
  // transition into its state, so the strobe lines up with AL_STATE.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    tmo_next     = tmo_reg;
    done_next    = done_reg;
    err_next     = err_reg;
    rd_req_next  = 1'b0;
    rd_addr_next = rd_addr_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (AL_START) begin
          state_next   = ST_REQ;
          done_next    = 1'b0;
          err_next     = 1'b0;
          cnt_next     = '0;
          rd_req_next  = 1'b1;
          rd_addr_next = '0;
        end
      end
      ST_REQ: begin
        state_next = ST_WAIT;
        tmo_next   = '0;
      end
      ST_WAIT: begin
        if (RD_VLD) begin
          state_next   = ST_WRITE;
          wr_data_next = RD_DATA;
          wr_addr_next = cnt_reg;
          wr_en_next   = 1'b1;
        end else if (tmo_reg == TMO_LAST) begin
          // Dead source: stop without writing this word.
          state_next = ST_DONE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      ST_WRITE: begin
        if (cnt_reg == LAST_WORD) begin
          state_next = ST_DONE;
          done_next  = 1'b1;
        end else begin
          state_next   = ST_REQ;
          cnt_next     = cnt_reg + 1'b1;
          rd_req_next  = 1'b1;
          rd_addr_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        // A new load needs AL_START to go low here first; there is no auto-restart.
        if (!AL_START) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign AL_STATE = state_reg;
  assign AL_DONE  = done_reg;
  assign AL_ERR   = err_reg;
  assign RD_REQ   = rd_req_reg;
  assign RD_ADDR  = rd_addr_reg;
  assign WR_EN    = wr_en_reg;
  assign WR_ADDR  = wr_addr_reg;
  assign WR_DATA  = wr_data_reg;

endmodule

// File: tb/tb_auto_load_seq.sv
// Testbench for auto_load_seq. It uses a readback-buffer responder with
// programmable delay, stray strobes and a dead word, plus a write monitor.
// Expected results come from the load rules: word i is written with
// base+i, and a load of words with response delays d_i takes
// sum(3 + d_i) cycles.
module tb_auto_load_seq;
  localparam int NWORDS = 16;
  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int TMO    = 1023;

  logic          CLK = 1'b0;
  logic          EOS;
  logic          AL_START;
  logic          AL_DONE, AL_ERR;
  logic [2:0]    AL_STATE;
  logic          RD_REQ;
  logic [AW-1:0] RD_ADDR;
  logic [DW-1:0] RD_DATA;
  logic          RD_VLD;
  logic          WR_EN;
  logic [AW-1:0] WR_ADDR;
  logic [DW-1:0] WR_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder controls, set by the test tasks.
  logic [DW-1:0] data_base = 16'hA500;
  int            dead_addr = -1;
  bit            rand_delay = 1'b0;
  bit            stray_en   = 1'b0;
  int            total_delay = 0;

  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];

  auto_load_seq #(.NWORDS(NWORDS), .AW(AW), .DW(DW), .TMO(TMO)) dut (
    .CLK(CLK), .EOS(EOS), .AL_START(AL_START), .AL_DONE(AL_DONE), .AL_ERR(AL_ERR),
    .AL_STATE(AL_STATE), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .RD_VLD(RD_VLD), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
  );

  always #5 CLK = ~CLK;

  // Write monitor: collect every config write in order.
  always @(negedge CLK) begin
    if (WR_EN === 1'b1) begin
      wq_addr.push_back(WR_ADDR);
      wq_data.push_back(WR_DATA);
    end
  end

  // Readback-buffer responder. It answers each read request after a delay of
  // d cycles, where d = 0 puts RD_VLD in the cycle after RD_REQ. Outside
  // Wait_Data it may also send stray strobes that carry garbage data.
  initial begin : responder
    bit      pending;
    int      countdown;
    int      d;
    logic [AW-1:0] pend_addr;
    pending = 1'b0; countdown = 0; pend_addr = '0;
    RD_VLD = 1'b0; RD_DATA = '0;
    forever begin
      @(posedge CLK); #1;
      RD_VLD  = 1'b0;
      RD_DATA = DW'($urandom);
      if (EOS !== 1'b1) begin
        pending = 1'b0;
      end else if (pending) begin
        if (countdown == 0) begin
          RD_VLD  = 1'b1;
          RD_DATA = data_base + DW'(pend_addr);
          pending = 1'b0;
        end else begin
          countdown--;
        end
      end
      if (!RD_VLD && stray_en && AL_STATE !== 3'd2 && $urandom_range(0, 1) == 1)
        RD_VLD = 1'b1;
      if (EOS === 1'b1 && RD_REQ === 1'b1 && int'(RD_ADDR) != dead_addr) begin
        d = rand_delay ? int'($urandom_range(0, 20)) : 0;
        pending   = 1'b1;
        countdown = d;
        pend_addr = RD_ADDR;
        total_delay += d;
      end
    end
  end

  // Stimulus only: raise AL_START and return what the DUT shows one edge later.
  task automatic start_load(output logic done0, output logic err0,
                            output logic req0, output logic [2:0] st0);
    wq_addr.delete(); wq_data.delete(); total_delay = 0;
    @(negedge CLK); AL_START = 1'b1;
    @(posedge CLK); #1;
    done0 = AL_DONE; err0 = AL_ERR; req0 = RD_REQ; st0 = AL_STATE;
  endtask

  // Stimulus only: count edges until AL_DONE rises, with a budget.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (AL_DONE !== 1'b1 && cyc < budget) begin
      @(posedge CLK); #1; cyc++;
    end
  endtask

  task automatic end_load();
    @(negedge CLK); AL_START = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    EOS = 1'b0; AL_START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({AL_DONE, AL_ERR, RD_REQ, WR_EN, AL_STATE, RD_ADDR, WR_ADDR, WR_DATA} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%b err=%b req=%b wen=%b st=%0d ra=%0h wa=%0h wd=%0h, expected all 0",
               AL_DONE, AL_ERR, RD_REQ, WR_EN, AL_STATE, RD_ADDR, WR_ADDR, WR_DATA);
    end
    @(negedge CLK); EOS = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    n_checks++;
    if (AL_STATE !== 3'd0 || AL_DONE !== 1'b0 || RD_REQ !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_hold: st=%0d done=%b req=%b, expected st=0 done=0 req=0", AL_STATE, AL_DONE, RD_REQ);
    end
  endtask

  task automatic test_nominal();
    logic d0, e0, r0; logic [2:0] s0; int cyc;
    data_base = 16'hA500; dead_addr = -1; rand_delay = 0; stray_en = 0;
    start_load(d0, e0, r0, s0);
    n_checks++;
    if (d0 !== 1'b0 || r0 !== 1'b1 || s0 !== 3'd1) begin
      n_fail++;
      $display("FAIL nominal_start: done=%b req=%b st=%0d, expected done=0 req=1 st=1", d0, r0, s0);
    end
    wait_done(200, cyc);
    n_checks++;
    if (cyc !== 3 * NWORDS) begin
      n_fail++; $display("FAIL nominal_latency: got %0d cycles, expected %0d", cyc, 3 * NWORDS);
    end
    n_checks++;
    if (AL_ERR !== 1'b0 || AL_STATE !== 3'd4) begin
      n_fail++; $display("FAIL nominal_status: err=%b st=%0d, expected err=0 st=4", AL_ERR, AL_STATE);
    end
    n_checks++;
    if (wq_addr.size() != NWORDS) begin
      n_fail++; $display("FAIL nominal_count: got %0d writes, expected %0d", wq_addr.size(), NWORDS);
    end
    for (int i = 0; i < wq_addr.size() && i < NWORDS; i++) begin
      n_checks++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== DW'(16'hA500 + i)) begin
        n_fail++;
        $display("FAIL nominal_write%0d: got %0h/%0h, expected %0h/%0h", i, wq_addr[i], wq_data[i], i, 16'hA500 + i);
      end
    end
    end_load();
  endtask

  task automatic test_timeout();
    logic d0, e0, r0; logic [2:0] s0; int cyc, wait5;
    data_base = DW'($urandom); dead_addr = 5; rand_delay = 0; stray_en = 0;
    start_load(d0, e0, r0, s0);
    cyc = 0; wait5 = 0;
    while (AL_DONE !== 1'b1 && cyc < 3000) begin
      @(posedge CLK); #1; cyc++;
      if (AL_STATE === 3'd2 && RD_ADDR === AW'(5)) wait5++;
    end
    n_checks++;
    if (cyc !== 3 * 5 + 1 + TMO) begin
      n_fail++; $display("FAIL timeout_latency: got %0d cycles, expected %0d", cyc, 3 * 5 + 1 + TMO);
    end
    n_checks++;
    if (wait5 !== TMO) begin
      n_fail++; $display("FAIL timeout_wait: got %0d cycles in Wait_Data, expected %0d", wait5, TMO);
    end
    n_checks++;
    if (AL_DONE !== 1'b1 || AL_ERR !== 1'b1) begin
      n_fail++; $display("FAIL timeout_flags: done=%b err=%b, expected done=1 err=1", AL_DONE, AL_ERR);
    end
    n_checks++;
    if (wq_addr.size() != 5) begin
      n_fail++; $display("FAIL timeout_count: got %0d writes, expected 5", wq_addr.size());
    end
    for (int i = 0; i < wq_addr.size() && i < 5; i++) begin
      n_checks++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== DW'(data_base + i)) begin
        n_fail++;
        $display("FAIL timeout_write%0d: got %0h/%0h, expected %0h/%0h", i, wq_addr[i], wq_data[i], i, DW'(data_base + i));
      end
    end
  endtask

  // This follows the timeout load, so AL_START is still high in Done.
  task automatic test_handshake();
    logic d0, e0, r0; logic [2:0] s0; int cyc;
    repeat (8) @(posedge CLK);
    #1;
    n_checks++;
    if (AL_STATE !== 3'd4 || AL_DONE !== 1'b1) begin
      n_fail++; $display("FAIL hold_done: st=%0d done=%b, expected st=4 done=1", AL_STATE, AL_DONE);
    end
    end_load();
    n_checks++;
    if (AL_STATE !== 3'd0 || AL_DONE !== 1'b1) begin
      n_fail++; $display("FAIL idle_keeps_done: st=%0d done=%b, expected st=0 done=1", AL_STATE, AL_DONE);
    end
    dead_addr = -1; data_base = DW'($urandom);
    start_load(d0, e0, r0, s0);
    n_checks++;
    if (d0 !== 1'b0 || e0 !== 1'b0 || r0 !== 1'b1) begin
      n_fail++; $display("FAIL restart: done=%b err=%b req=%b, expected done=0 err=0 req=1", d0, e0, r0);
    end
    wait_done(200, cyc);
    n_checks++;
    if (cyc !== 3 * NWORDS || AL_ERR !== 1'b0 || wq_addr.size() != NWORDS) begin
      n_fail++; $display("FAIL reload: cycles=%0d err=%b writes=%0d, expected %0d/0/%0d", cyc, AL_ERR, wq_addr.size(), 3 * NWORDS, NWORDS);
    end
    end_load();
  endtask

  task automatic test_random_response();
    logic d0, e0, r0; logic [2:0] s0; int cyc;
    for (int run = 0; run < 3; run++) begin
      data_base = DW'($urandom); dead_addr = -1; rand_delay = 1; stray_en = 1;
      start_load(d0, e0, r0, s0);
      wait_done(NWORDS * 25 + 10, cyc);
      n_checks++;
      if (cyc !== 3 * NWORDS + total_delay || AL_ERR !== 1'b0) begin
        n_fail++;
        $display("FAIL random%0d_timing: cycles=%0d err=%b, expected %0d/0", run, cyc, AL_ERR, 3 * NWORDS + total_delay);
      end
      n_checks++;
      if (wq_addr.size() != NWORDS) begin
        n_fail++; $display("FAIL random%0d_count: got %0d writes, expected %0d", run, wq_addr.size(), NWORDS);
      end
      for (int i = 0; i < wq_addr.size() && i < NWORDS; i++) begin
        n_checks++;
        if (wq_addr[i] !== AW'(i) || wq_data[i] !== DW'(data_base + i)) begin
          n_fail++;
          $display("FAIL random%0d_write%0d: got %0h/%0h, expected %0h/%0h", run, i, wq_addr[i], wq_data[i], i, DW'(data_base + i));
        end
      end
      end_load();
    end
    stray_en = 0; rand_delay = 0;
  endtask

  task automatic test_midload_reset();
    logic d0, e0, r0; logic [2:0] s0; int cyc;
    data_base = DW'($urandom); dead_addr = -1;
    start_load(d0, e0, r0, s0);
    cyc = 0;
    while (!(RD_REQ === 1'b1 && RD_ADDR === AW'(7)) && cyc < 100) begin
      @(posedge CLK); #1; cyc++;
    end
    n_checks++;
    if (cyc >= 100) begin
      n_fail++; $display("FAIL midreset_reach: word 7 request not seen, got %0d cycles, expected < 100", cyc);
    end
    @(posedge CLK); #3;
    EOS = 1'b0;
    #1;
    n_checks++;
    if ({AL_DONE, AL_ERR, RD_REQ, WR_EN, AL_STATE, RD_ADDR, WR_ADDR, WR_DATA} !== '0) begin
      n_fail++;
      $display("FAIL midreset_async: done=%b req=%b wen=%b st=%0d ra=%0h wa=%0h wd=%0h, expected all 0",
               AL_DONE, RD_REQ, WR_EN, AL_STATE, RD_ADDR, WR_ADDR, WR_DATA);
    end
    n_checks++;
    if (wq_addr.size() != 7) begin
      n_fail++; $display("FAIL midreset_partial: got %0d writes, expected 7", wq_addr.size());
    end
    AL_START = 1'b0;
    @(negedge CLK); EOS = 1'b1;
    repeat (2) @(posedge CLK);
    data_base = DW'($urandom);
    start_load(d0, e0, r0, s0);
    wait_done(200, cyc);
    n_checks++;
    if (cyc !== 3 * NWORDS || AL_ERR !== 1'b0 || wq_addr.size() != NWORDS) begin
      n_fail++; $display("FAIL midreset_reload: cycles=%0d err=%b writes=%0d, expected %0d/0/%0d", cyc, AL_ERR, wq_addr.size(), 3 * NWORDS, NWORDS);
    end
    for (int i = 0; i < wq_addr.size() && i < NWORDS; i++) begin
      n_checks++;
      if (wq_addr[i] !== AW'(i) || wq_data[i] !== DW'(data_base + i)) begin
        n_fail++;
        $display("FAIL midreset_write%0d: got %0h/%0h, expected %0h/%0h", i, wq_addr[i], wq_data[i], i, DW'(data_base + i));
      end
    end
    end_load();
  endtask

  initial begin
    test_reset();
    $display("reset test done");
    test_nominal();
    $display("nominal load done");
    test_timeout();
    $display("timeout load done");
    test_handshake();
    $display("handshake reload done");
    test_random_response();
    $display("random response loads done");
    test_midload_reset();
    $display("mid-load reset done");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
